// File: rtl/bit32div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bit32div_pkg;

    // Operand, quotient and remainder width used when the top is not overridden.
    localparam int DEFAULT_WIDTH = 32;

    // Controller state encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/bit32div_bitnsub.sv
// N-bit combinational subtractor x - y built as x + ~y + 1 with a propagate/generate carry chain.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module bitnsub #(
    parameter int N = 33
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N-1:0] y_inv;
    logic [N-1:0] prop;
    logic [N-1:0] gen;
    logic [N:0]   carry;

    assign y_inv = ~y;
    assign prop  = x ^ y_inv;
    assign gen   = x & y_inv;

    // Ripple the carry through generate/propagate terms; carry-in of 1 completes the two's complement of y.
    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < N; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign diff   = prop ^ carry[N-1:0];
    // No carry out of the top means y > x.
    assign borrow = ~carry[N];

endmodule

// File: rtl/bit32div.sv
// Sequential unsigned restoring divider producing one quotient bit per clock.
// Latency: WIDTH+1 cycles from accepting edge to done (1 cycle when b=0).
// Backpressure: start is accepted only while busy=0; starts during a run are dropped.
module bit32div
    import bit32div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             dbz
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] b_reg;
    // Partial remainder stays below the divisor, so WIDTH bits hold it; the extra
    // bit of the trial difference only serves as its sign.
    logic [WIDTH-1:0] r_reg;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last_iter;
    logic [WIDTH:0]   sub_x;
    logic [WIDTH:0]   sub_y;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic             neg;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] r_nxt;

    assign accept    = start && (state != RUN);
    assign last_iter = (state == RUN) && (cnt == LAST);

    // Shift the next dividend bit into the partial remainder and trial-subtract the divisor.
    assign sub_x = {r_reg, q_reg[WIDTH-1]};
    assign sub_y = {1'b0, b_reg};

    bitnsub #(
        .N(WIDTH + 1)
    ) u_sub (
        .x     (sub_x),
        .y     (sub_y),
        .diff  (trial),
        .borrow(borrow)
    );

    // Either flag marks a negative trial; they agree because the remainder stays below B.
    assign neg   = trial[WIDTH] | borrow;
    assign q_nxt = {q_reg[WIDTH-2:0], ~neg};
    // On restore the shifted value is below B, so its top bit is zero and can be dropped.
    assign r_nxt = neg ? sub_x[WIDTH-1:0] : trial[WIDTH-1:0];

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a zero divisor skips the iterations and completes immediately.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (b == '0) ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, one restoring step per RUN cycle, result registers updated only at completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
            b_reg <= '0;
            r_reg <= '0;
            cnt   <= '0;
            quot  <= '0;
            rem   <= '0;
            dbz   <= 1'b0;
        end else if (accept) begin
            q_reg <= a;
            b_reg <= b;
            r_reg <= '0;
            cnt   <= '0;
            if (b == '0) begin
                quot <= '1;
                rem  <= a;
                dbz  <= 1'b1;
            end
        end else if (state == RUN) begin
            q_reg <= q_nxt;
            r_reg <= r_nxt;
            cnt   <= cnt + 1'b1;
            if (last_iter) begin
                quot <= q_nxt;
                rem  <= r_nxt;
                dbz  <= 1'b0;
            end
        end
    end

endmodule
